// File: rtl/wb_port_arbiter_if.sv
// Producer/write-port bundle between the three result producers, the
// writeback arbiter and the dual-write-port register file.
interface wb_port_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              req0_valid, req1_valid, req2_valid;
    logic [ADDR_W-1:0] req0_rd,    req1_rd,    req2_rd;
    logic [DATA_W-1:0] req0_data,  req1_data,  req2_data;
    logic              req0_ready, req1_ready, req2_ready;

    logic [ADDR_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] wb_data1, wb_data2;
    logic              wb_we1, wb_we2;

    modport master (
        output req0_valid, req1_valid, req2_valid,
        output req0_rd, req1_rd, req2_rd,
        output req0_data, req1_data, req2_data,
        input  req0_ready, req1_ready, req2_ready,
        input  rd1, rd2, wb_data1, wb_data2, wb_we1, wb_we2
    );

    modport slave (
        input  req0_valid, req1_valid, req2_valid,
        input  req0_rd, req1_rd, req2_rd,
        input  req0_data, req1_data, req2_data,
        output req0_ready, req1_ready, req2_ready,
        output rd1, rd2, wb_data1, wb_data2, wb_we1, wb_we2
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter: grants up to two of three producers onto two
// register-file write ports, never two same-cycle writes to one register.
// Optional WB_STALL_CNT_EN adds a 32-bit stall_cnt of valid-but-not-ready cycles.
module wb_port_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic clk,
    input  logic rst,
    wb_port_arbiter_if.slave bus
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    logic [2:0]        valid;
    logic [ADDR_W-1:0] rd   [3];
    logic [DATA_W-1:0] data [3];

    assign valid   = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
    assign rd[0]   = bus.req0_rd;
    assign rd[1]   = bus.req1_rd;
    assign rd[2]   = bus.req2_rd;
    assign data[0] = bus.req0_data;
    assign data[1] = bus.req1_data;
    assign data[2] = bus.req2_data;

    logic [ADDR_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
    logic              we1_q, we1_d, we2_q, we2_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;

    logic [2:0] cand, elig, grant, ready;
    logic       g1_vld, g2_vld;
    logic [1:0] g1_idx, g2_idx, idx;
    logic [2:0] sum;

    // Candidate filtering, round-robin scan and next-state computation
    always_comb begin
        cand   = '0;
        elig   = '0;
        grant  = '0;
        g1_vld = 1'b0;
        g2_vld = 1'b0;
        g1_idx = 2'd0;
        g2_idx = 2'd0;
        idx    = 2'd0;
        sum    = 3'd0;

        for (int i = 0; i < 3; i++) cand[i] = valid[i] && (rd[i] != '0);

        // Among candidates sharing an rd only the lowest index stays eligible
        for (int i = 0; i < 3; i++) begin
            elig[i] = cand[i];
            for (int j = 0; j < 3; j++)
                if (j < i && cand[j] && rd[j] == rd[i]) elig[i] = 1'b0;
        end

        for (int k = 0; k < 3; k++) begin
            sum = 3'(rr_ptr_q) + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
            if (elig[idx]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = idx;
                end else if (!g2_vld && rd[idx] != rd[g1_idx]) begin
                    g2_vld = 1'b1;
                    g2_idx = idx;
                end
            end
        end

        if (g1_vld) grant[g1_idx] = 1'b1;
        if (g2_vld) grant[g2_idx] = 1'b1;

        for (int i = 0; i < 3; i++)
            ready[i] = !rst && ((valid[i] && rd[i] == '0) || grant[i]);

        we1_d   = g1_vld;
        rd1_d   = g1_vld ? rd[g1_idx]   : rd1_q;
        data1_d = g1_vld ? data[g1_idx] : data1_q;
        we2_d   = g2_vld;
        rd2_d   = g2_vld ? rd[g2_idx]   : rd2_q;
        data2_d = g2_vld ? data[g2_idx] : data2_q;

        if (g2_vld)      rr_ptr_d = (g2_idx == 2'd2) ? 2'd0 : g2_idx + 2'd1;
        else if (g1_vld) rr_ptr_d = (g1_idx == 2'd2) ? 2'd0 : g1_idx + 2'd1;
        else             rr_ptr_d = rr_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_q    <= '0;
            rd2_q    <= '0;
            data1_q  <= '0;
            data2_q  <= '0;
            we1_q    <= 1'b0;
            we2_q    <= 1'b0;
            rr_ptr_q <= 2'd0;
        end else begin
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            data1_q  <= data1_d;
            data2_q  <= data2_d;
            we1_q    <= we1_d;
            we2_q    <= we2_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [1:0]  n_stall;

    // Each valid requester left waiting this cycle adds one
    always_comb begin
        n_stall = 2'd0;
        for (int i = 0; i < 3; i++) n_stall = n_stall + 2'(valid[i] && !ready[i]);
        stall_cnt_d = stall_cnt_q + 32'(n_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.req2_ready = ready[2];
    assign bus.rd1        = rd1_q;
    assign bus.rd2        = rd2_q;
    assign bus.wb_data1   = data1_q;
    assign bus.wb_data2   = data2_q;
    assign bus.wb_we1     = we1_q;
    assign bus.wb_we2     = we2_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with a small register-file
// model behind the write ports.
module tb_wb_port_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cnt;
    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt));
`else
    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_viol   = 0;
    logic [DATA_W-1:0] rf [32];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register file with port-1 priority, plus write-port guarantee monitor
    always @(posedge clk) begin
        if (bus.wb_we1 && bus.wb_we2 && bus.rd1 == bus.rd2) n_viol++;
        if ((bus.wb_we1 && bus.rd1 == '0) || (bus.wb_we2 && bus.rd2 == '0)) n_viol++;
        if (bus.wb_we2) rf[bus.rd2] <= bus.wb_data2;
        if (bus.wb_we1) rf[bus.rd1] <= bus.wb_data1;
    end

    task automatic drive(input logic [2:0] v,
                         input logic [ADDR_W-1:0] a0, a1, a2,
                         input logic [DATA_W-1:0] d0, d1, d2);
        bus.req0_valid = v[0]; bus.req0_rd = a0; bus.req0_data = d0;
        bus.req1_valid = v[1]; bus.req1_rd = a1; bus.req1_data = d1;
        bus.req2_valid = v[2]; bus.req2_rd = a2; bus.req2_data = d2;
    endtask

    // Check ready mid-cycle, then advance past the next rising edge
    task automatic step(input string tag, input logic [2:0] exp_rdy);
        #1;
        check_eq({tag, "_rdy"}, {bus.req2_ready, bus.req1_ready, bus.req0_ready}, exp_rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input string tag,
                             input logic we1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                             input logic we2, input logic [ADDR_W-1:0] a2, input logic [DATA_W-1:0] d2);
        check_eq({tag, "_p1"}, {bus.wb_we1, 27'(bus.rd1), bus.wb_data1}, {we1, 27'(a1), d1});
        check_eq({tag, "_p2"}, {bus.wb_we2, 27'(bus.rd2), bus.wb_data2}, {we2, 27'(a2), d2});
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rst = 1'b1;
        drive(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3);
        @(negedge clk);

        // Reset held two cycles with all requesters valid
        step("rst0", 3'b000);
        expect_wb("rst0", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step("rst1", 3'b000);
        expect_wb("rst1", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;

        // Three-way: req0/req1 first, req2 one cycle later on port 1
        step("three_a", 3'b011);
        expect_wb("three_a", 1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
        drive(3'b100, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3);
        step("three_b", 3'b100);
        expect_wb("three_b", 1'b1, 5'd3, 32'hA3, 1'b0, 5'd2, 32'hA2);

        // Dual grant
        drive(3'b011, 5'd3, 5'd7, 5'd0, 32'h11, 32'h22, 32'h0);
        step("dual", 3'b011);
        expect_wb("dual", 1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);

        // Same rd with rr_ptr=2: lower index wins, req2 follows
        drive(3'b110, 5'd0, 5'd9, 5'd9, 32'h0, 32'hA, 32'hB);
        step("same_a", 3'b010);
        expect_wb("same_a", 1'b1, 5'd9, 32'hA, 1'b0, 5'd7, 32'h22);
        drive(3'b100, 5'd0, 5'd9, 5'd9, 32'h0, 32'hA, 32'hB);
        step("same_b", 3'b100);
        expect_wb("same_b", 1'b1, 5'd9, 32'hB, 1'b0, 5'd7, 32'h22);

        // rd==0 accepted without using a port
        drive(3'b111, 5'd0, 5'd4, 5'd5, 32'hDEAD, 32'h44, 32'h55);
        step("rd0", 3'b111);
        expect_wb("rd0", 1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55);

        // Idle: enables drop, addresses/data held
        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        step("idle", 3'b000);
        expect_wb("idle", 1'b0, 5'd4, 32'h44, 1'b0, 5'd5, 32'h55);
        check_eq("rf_x9", 64'(rf[9]), 64'h0B);
        check_eq("rf_x0", 64'(rf[0]), 64'h0);

        // Mid-stream reset, then a sustained three-way load
        drive(3'b111, 5'd10, 5'd11, 5'd12, 32'hC0, 32'hC1, 32'hC2);
        rst = 1'b1;
        step("rst_mid", 3'b000);
        expect_wb("rst_mid", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        step("load1", 3'b011);
`ifdef WB_STALL_CNT_EN
        check_eq("stall1", 64'(stall_cnt), 64'd1);
`endif
        expect_wb("load1", 1'b1, 5'd10, 32'hC0, 1'b1, 5'd11, 32'hC1);
        step("load2", 3'b101);
`ifdef WB_STALL_CNT_EN
        check_eq("stall2", 64'(stall_cnt), 64'd2);
`endif
        expect_wb("load2", 1'b1, 5'd12, 32'hC2, 1'b1, 5'd10, 32'hC0);
        step("load3", 3'b110);
`ifdef WB_STALL_CNT_EN
        check_eq("stall3", 64'(stall_cnt), 64'd3);
`endif
        expect_wb("load3", 1'b1, 5'd11, 32'hC1, 1'b1, 5'd12, 32'hC2);
        step("load4", 3'b011);
`ifdef WB_STALL_CNT_EN
        check_eq("stall4", 64'(stall_cnt), 64'd4);
`endif
        expect_wb("load4", 1'b1, 5'd10, 32'hC0, 1'b1, 5'd11, 32'hC1);

        drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("guarantee", 64'(n_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
